ram_arbiter: RTL and testbench

- Shares one single-port, synchronous-read word RAM between the instruction-fetch port (I) and the load/store port (D) of the RV32 core.
- Sits between the core and the RAM and owns every RAM control signal.
- Sequences partial-word stores (byte strobes) as a read-modify-write, because the RAM supports full-word writes only.
- RAM contract: one-cycle read latency; when write-enable is high, no read occurs and the read-data register holds.

---
 rtl/ram_arbiter.sv | 98 +++++++++
 tb/tb_ram_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port sync-read RAM between fetch (I) and load/store (D) ports,
// turning partial-word stores into read-modify-write. Define RAM_ARB_RR_EN for round-robin arbitration.
module ram_arbiter #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            ram_we,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_wdata,
    input  logic [DW-1:0]   ram_rdata
);
    localparam int BW = DW / 8;

    typedef enum logic {IDLE, MERGE} state_t;

    state_t          state;
    logic [AW-1:0]   addr_q;
    logic [BW-1:0]   be_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   merged;
    logic            d_win;
    logic            idle;
    logic            full;
    logic            part;
    logic            d_acc;

    assign idle = (state == IDLE) && rst_n;

`ifdef RAM_ARB_RR_EN
    logic last_d;
    assign d_win = d_req && (!i_req || !last_d);
`else
    assign d_win = d_req;
`endif

    assign d_gnt = idle && d_win;
    assign i_gnt = idle && i_req && !d_win;
    assign full  = &d_be;
    assign part  = |d_be && !full;
    // a zero-strobe store is granted but touches nothing
    assign d_acc = d_gnt && (!d_we || |d_be);

    always_comb begin
        merged = '0;
        for (int n = 0; n < BW; n++)
            merged[8*n +: 8] = be_q[n] ? wdata_q[8*n +: 8] : ram_rdata[8*n +: 8];
    end

    assign ram_we    = (state == MERGE) || (d_gnt && d_we && full);
    assign ram_addr  = d_acc ? d_addr : i_gnt ? i_addr : addr_q;
    assign ram_wdata = (state == MERGE) ? merged : (d_gnt && d_we) ? d_wdata : wdata_q;
    assign i_rdata   = ram_rdata;
    assign d_rdata   = ram_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
        end else begin
            state    <= (d_gnt && d_we && part) ? MERGE : IDLE;
            addr_q   <= ram_addr;
            i_rvalid <= i_gnt;
            d_rvalid <= d_gnt && !d_we;
            if (d_gnt && d_we) begin
                be_q    <= d_be;
                wdata_q <= d_wdata;
            end
        end
    end

`ifdef RAM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_d <= 1'b0;
        else if (d_gnt || i_gnt)
            last_d <= d_gnt;
    end
`endif
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized and directed checks of ram_arbiter against a transaction-level memory model.
module tb_ram_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [15:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;

    logic [31:0] mem [0:16383];
    logic [31:0] ref_mem [0:15];

    int checks = 0, errors = 0;

    logic        i_pend = 0, d_pend = 0;
    logic [15:0] n_iaddr = '0, n_daddr = '0;
    logic        n_dwe = 0;
    logic [3:0]  n_dbe = '0;
    logic [31:0] n_dwdata = '0;

    logic        m_busy = 0, m_irv = 0, m_drv = 0, m_last_d = 0;
    logic [31:0] m_idata = '0, m_ddata = '0, m_saved = '0;
    logic [3:0]  m_waddr = '0;

    ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[15:2]] <= ram_wdata;
        else ram_rdata <= mem[ram_addr[15:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one bus cycle: check last cycle's responses, drive requests, check grants, advance the model
    task automatic step();
        logic gd, gi, full, part;
        logic [3:0] w;
        @(negedge clk);
        check("i_rvalid", {31'b0, i_rvalid}, {31'b0, m_irv});
        if (m_irv) check("i_rdata", i_rdata, m_idata);
        check("d_rvalid", {31'b0, d_rvalid}, {31'b0, m_drv});
        if (m_drv) check("d_rdata", d_rdata, m_ddata);
        i_req = i_pend; i_addr = n_iaddr;
        d_req = d_pend; d_we = n_dwe; d_be = n_dbe; d_addr = n_daddr; d_wdata = n_dwdata;
        #1;
`ifdef RAM_ARB_RR_EN
        gd = !m_busy && d_pend && (!i_pend || !m_last_d);
`else
        gd = !m_busy && d_pend;
`endif
        gi = !m_busy && i_pend && !gd;
        full = (n_dbe == 4'hF);
        part = (n_dbe != 4'h0) && !full;
        check("d_gnt", {31'b0, d_gnt}, {31'b0, gd});
        check("i_gnt", {31'b0, i_gnt}, {31'b0, gi});
        check("ram_we", {31'b0, ram_we}, {31'b0, m_busy || (gd && n_dwe && full)});
        if (m_busy) check("merge_wdata", ram_wdata, ref_mem[m_waddr]);
        m_irv = 0;
        m_drv = 0;
        if (gd) begin
            w = n_daddr[5:2];
            if (!n_dwe || n_dbe != 0) check("d_ram_addr", {16'b0, ram_addr}, {16'b0, n_daddr});
            if (n_dwe) begin
                m_saved = ref_mem[w];
                m_waddr = w;
                for (int b = 0; b < 4; b++)
                    if (n_dbe[b]) ref_mem[w][8*b +: 8] = n_dwdata[8*b +: 8];
                if (full) check("full_wdata", ram_wdata, ref_mem[w]);
            end else begin
                m_drv = 1;
                m_ddata = ref_mem[w];
            end
            d_pend = 0;
        end
        if (gi) begin
            check("i_ram_addr", {16'b0, ram_addr}, {16'b0, n_iaddr});
            m_irv = 1;
            m_idata = ref_mem[n_iaddr[5:2]];
            i_pend = 0;
        end
        if (gd || gi) m_last_d = gd;
        m_busy = gd && n_dwe && part;
        @(posedge clk);
    endtask

    task automatic set_d(input logic we, input logic [3:0] be, input logic [15:0] a, input logic [31:0] wd);
        d_pend = 1; n_dwe = we; n_dbe = be; n_daddr = a; n_dwdata = wd;
    endtask

    task automatic set_i(input logic [15:0] a);
        i_pend = 1; n_iaddr = a;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            ref_mem[k] = $urandom;
            mem[k] = ref_mem[k];
        end
        ref_mem[4] = 32'hAABBCCDD;
        mem[4] = 32'hAABBCCDD;
        i_req = 1; d_req = 1; d_we = 0; d_addr = 16'h0010; i_addr = 16'h0014;
        #12;
        check("rst_i_gnt", {31'b0, i_gnt}, 32'h0);
        check("rst_d_gnt", {31'b0, d_gnt}, 32'h0);
        check("rst_ram_we", {31'b0, ram_we}, 32'h0);
        check("rst_ram_addr", {16'b0, ram_addr}, 32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        check("rst_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'h0);
        i_req = 0; d_req = 0;
        @(negedge clk) rst_n = 1;
        @(posedge clk);

        set_i(16'h0010); step(); step(); step();
        check("t1_word", ref_mem[4], 32'hAABBCCDD);

        set_d(1, 4'b0100, 16'h0010, 32'h00110000); step();
        #2 check("t2_merge", ram_wdata, 32'hAA11CCDD);
        step();
        set_d(0, 4'h0, 16'h0010, 32'h0); step(); step();
        check("t2_ref", m_ddata, 32'hAA11CCDD);

        set_i(16'h0004);
        for (int k = 0; k < 4; k++) begin
            set_d(0, 4'h0, 16'h0008, 32'h0);
            if (!i_pend) set_i(16'h0004);
            step();
        end
        d_pend = 0; i_pend = 0; step(); step();

        set_d(1, 4'b0001, 16'h0018, 32'h000000EE); step();
        set_i(16'h0018); step(); step(); step();

        set_d(1, 4'hF, 16'h0020, 32'hDEADBEEF); step();
        set_d(0, 4'h0, 16'h0020, 32'h0); step(); step(); step();
        check("t5_ref", m_ddata, 32'hDEADBEEF);

        set_d(1, 4'h0, 16'h0024, 32'h12345678); step(); step();

        for (int c = 0; c < 400; c++) begin
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0: set_d(1, 4'hF, 16'($urandom_range(0, 15) * 4), $urandom);
                    1: set_d(1, 4'($urandom), 16'($urandom_range(0, 15) * 4), $urandom);
                    default: set_d(0, 4'h0, 16'($urandom_range(0, 15) * 4), 32'h0);
                endcase
            end
            if (!i_pend && $urandom_range(0, 1) == 0) set_i(16'($urandom_range(0, 15) * 4));
            step();
        end
        while (d_pend || i_pend) step();
        step(); step();

        set_d(1, 4'b0010, 16'h0020, 32'h00005500); step();
        #2 check("t6_we_merge", {31'b0, ram_we}, 32'h1);
        rst_n = 0;
        #1 check("t6_we_rst", {31'b0, ram_we}, 32'h0);
        check("t6_rvalid_rst", {30'b0, i_rvalid, d_rvalid}, 32'h0);
        ref_mem[m_waddr] = m_saved;
        m_busy = 0; m_irv = 0; m_drv = 0; m_last_d = 0; d_pend = 0; i_pend = 0;
        d_req = 0; i_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        set_d(0, 4'h0, 16'h0020, 32'h0); step(); step();
        check("t6_unchanged", m_ddata, m_saved);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
